// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bus bundle: instruction-memory request/ack and decode-side instruction stream
//
// Signals:
//   redirect/target        : taken branch/jump and its next-PC address
//   imem_req/imem_addr     : registered fetch request to instruction memory
//   imem_ack/imem_data     : one-cycle completion pulse with the fetched word
//   instr/instr_pc         : instruction and its address at the buffer head
//   instr_valid/instr_ready: decode handshake on the buffer head
// Modports: master = fetch unit side, slave = memory/decode/branch side.
interface fetch_unit_if;
  logic        redirect;
  logic [31:0] target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    input  redirect, target, imem_ack, imem_data, instr_ready,
    output imem_req, imem_addr, instr, instr_pc, instr_valid
  );

  modport slave (
    output redirect, target, imem_ack, imem_data, instr_ready,
    input  imem_req, imem_addr, instr, instr_pc, instr_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with one outstanding request and a 2-entry {pc, instr} buffer
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fetch_unit_if.master (redirect/target in, imem request out,
//           imem ack/data in, instruction stream out with valid/ready)
// Parameter RESET_PC is the first fetch address after reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  // FETCH: request outstanding (or about to be issued right after reset)
  // HOLD : no request, buffer full
  // DROP : request outstanding whose data is discarded because of a redirect
  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] pc_mem_q [2];
  logic [31:0] pc_mem_d [2];
  logic [31:0] instr_mem_q [2];
  logic [31:0] instr_mem_d [2];

  logic ack_v;
  logic push;
  logic pop;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    pc_d        = pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    // An ack only counts against a request we actually have outstanding.
    ack_v = bus.imem_ack & req_q;
    pop   = (count_q != 2'd0) & bus.instr_ready & ~bus.redirect;
    push  = ack_v & (state_q == FETCH) & ~bus.redirect;

    if (push) begin
      pc_mem_d[wr_ptr_q]    = addr_q;
      instr_mem_d[wr_ptr_q] = bus.imem_data;
      wr_ptr_d              = ~wr_ptr_q;
      pc_d                  = addr_q + 32'd4;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    if (bus.redirect) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      pc_d     = {bus.target[31:2], 2'b00};
    end

    if (req_q && !ack_v) begin
      // Request still in flight: request/address must stay stable. A redirect
      // now means its data must be thrown away when it eventually returns.
      if (bus.redirect) begin
        state_d = DROP;
      end
    end else if (count_d != 2'd2) begin
      // Nothing in flight after this edge and room for the result: issue.
      req_d   = 1'b1;
      addr_d  = pc_d;
      state_d = FETCH;
    end else begin
      req_d   = 1'b0;
      state_d = HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      req_q       <= 1'b0;
      addr_q      <= RESET_PC;
      pc_q        <= RESET_PC;
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      pc_mem_q    <= '{default: 32'h0};
      instr_mem_q <= '{default: 32'h0};
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      pc_q        <= pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr       = instr_mem_q[rd_ptr_q];
  assign bus.instr_pc    = pc_mem_q[rd_ptr_q];
  assign bus.instr_valid = (count_q != 2'd0);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic clk;
  logic rst_n;
  logic rst_nb;

  fetch_unit_if ia ();
  fetch_unit_if ib ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_b (.clk(clk), .rst_n(rst_nb), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] target;
    int          delay;
    bit          coincident;
    bit          redir2;
    logic [31:0] target2;
    logic [31:0] exp_addr;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[5];

  int checks = 0;
  int errors = 0;
  bit mem_en = 0;
  int mem_delay = 0;
  int wait_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pop actual_pc=%h required=none", ia.instr_pc);
    end else begin
      e = sb_q.pop_front();
      chk("pop_pc", ia.instr_pc, e.pc);
      chk("pop_instr", ia.instr, e.instr);
    end
  endtask

  // One clock of DUT A: score the pop happening at this edge, then let the
  // memory model react to the outputs after the edge.
  task automatic cycle();
    if (ia.instr_valid && ia.instr_ready && !ia.redirect) check_pop();
    @(posedge clk);
    #1;
    if (mem_en) begin
      if (ia.imem_req) begin
        if (wait_cnt >= mem_delay) begin
          ia.imem_ack  = 1'b1;
          ia.imem_data = ia.imem_addr ^ K;
          wait_cnt     = 0;
        end else begin
          ia.imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        ia.imem_ack = 1'b0;
        wait_cnt    = 0;
      end
    end
  endtask

  task automatic do_reset(input bit check);
    mem_en = 0;
    wait_cnt = 0;
    ia.imem_ack = 1'b0;
    ia.redirect = 1'b0;
    ia.instr_ready = 1'b0;
    sb_q.delete();
    rst_n = 1'b0;
    cycle();
    cycle();
    if (check) begin
      chk("rst_req", {31'b0, ia.imem_req}, 32'h0);
      chk("rst_addr", ia.imem_addr, 32'h0);
      chk("rst_valid", {31'b0, ia.instr_valid}, 32'h0);
      chk("rst_instr", ia.instr, 32'h0);
      chk("rst_instr_pc", ia.instr_pc, 32'h0);
    end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic ack_pulse(input logic [31:0] data);
    ia.imem_ack = 1'b1;
    ia.imem_data = data;
    cycle();
    ia.imem_ack = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && sb_q.size() > 0; i++) cycle();
    chk(name, sb_q.size(), 32'd0);
    ia.instr_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{target: 32'h0000_0100, delay: 3, coincident: 0, redir2: 0, target2: 32'h0, exp_addr: 32'h0000_0100};
    vecs[1] = '{target: 32'h0000_0203, delay: 0, coincident: 1, redir2: 0, target2: 32'h0, exp_addr: 32'h0000_0200};
    vecs[2] = '{target: 32'h0000_0FFF, delay: 1, coincident: 0, redir2: 0, target2: 32'h0, exp_addr: 32'h0000_0FFC};
    vecs[3] = '{target: 32'h0000_0040, delay: 3, coincident: 0, redir2: 1, target2: 32'h0000_0382, exp_addr: 32'h0000_0380};
    vecs[4] = '{target: 32'hFFFF_FFFE, delay: 0, coincident: 1, redir2: 0, target2: 32'h0, exp_addr: 32'hFFFF_FFFC};

    ia.redirect = 0; ia.target = 0; ia.imem_ack = 0; ia.imem_data = 0; ia.instr_ready = 0;
    ib.redirect = 0; ib.target = 0; ib.imem_ack = 0; ib.imem_data = 0; ib.instr_ready = 0;
    rst_nb = 1'b0;
    rst_n = 1'b0;
    #1;

    // Reset values, first request, then in-order stream with ACK latency 2.
    do_reset(1'b1);
    chk("first_req", {31'b0, ia.imem_req}, 32'h1);
    chk("first_addr", ia.imem_addr, 32'h0);
    for (int i = 0; i < 16; i++) sb_q.push_back('{pc: 32'(i * 4), instr: 32'(i * 4) ^ K});
    mem_delay = 2;
    mem_en = 1;
    ia.instr_ready = 1'b1;
    drain("seq_drain", 300);

    // Full buffer with decode stalled, then a single pop re-opens fetch.
    do_reset(1'b0);
    mem_delay = 0;
    mem_en = 1;
    for (int i = 0; i < 8; i++) cycle();
    chk("hold_req", {31'b0, ia.imem_req}, 32'h0);
    chk("hold_valid", {31'b0, ia.instr_valid}, 32'h1);
    chk("hold_head_pc", ia.instr_pc, 32'h0);
    chk("hold_head_instr", ia.instr, K);
    sb_q.push_back('{pc: 32'h0, instr: K});
    ia.instr_ready = 1'b1;
    cycle();
    ia.instr_ready = 1'b0;
    chk("refetch_req", {31'b0, ia.imem_req}, 32'h1);
    chk("refetch_addr", ia.imem_addr, 32'h8);
    chk("refetch_head_pc", ia.instr_pc, 32'h4);
    chk("refetch_sb", sb_q.size(), 32'd0);

    // Redirect in HOLD with decode ready: redirect wins, buffer empties.
    do_reset(1'b0);
    mem_delay = 0;
    mem_en = 1;
    for (int i = 0; i < 8; i++) cycle();
    mem_en = 0;
    ia.imem_ack = 1'b0;
    ia.redirect = 1'b1;
    ia.target = 32'h0000_0041;
    ia.instr_ready = 1'b1;
    cycle();
    ia.redirect = 1'b0;
    ia.instr_ready = 1'b0;
    chk("hold_redir_valid", {31'b0, ia.instr_valid}, 32'h0);
    chk("hold_redir_req", {31'b0, ia.imem_req}, 32'h1);
    chk("hold_redir_addr", ia.imem_addr, 32'h40);

    // Table: redirect against a request for 8 that is outstanding.
    foreach (vecs[v]) begin
      do_reset(1'b0);
      ack_pulse(K);
      ack_pulse(32'h4 ^ K);
      sb_q.push_back('{pc: 32'h0, instr: K});
      ia.instr_ready = 1'b1;
      cycle();
      ia.instr_ready = 1'b0;
      chk($sformatf("v%0d_pre_addr", v), ia.imem_addr, 32'h8);
      ia.redirect = 1'b1;
      ia.target = vecs[v].target;
      if (vecs[v].coincident) begin
        ack_pulse(32'h8 ^ K);
        ia.redirect = 1'b0;
      end else begin
        cycle();
        ia.redirect = 1'b0;
        chk($sformatf("v%0d_drop_valid", v), {31'b0, ia.instr_valid}, 32'h0);
        chk($sformatf("v%0d_drop_addr", v), ia.imem_addr, 32'h8);
        for (int i = 1; i < vecs[v].delay; i++) begin
          if (i == 1 && vecs[v].redir2) begin
            ia.redirect = 1'b1;
            ia.target = vecs[v].target2;
          end
          cycle();
          ia.redirect = 1'b0;
          chk($sformatf("v%0d_drop_hold", v), {ia.imem_addr[31:1], ia.imem_req}, 32'h9);
        end
        ack_pulse(32'h8 ^ K);
      end
      chk($sformatf("v%0d_valid", v), {31'b0, ia.instr_valid}, 32'h0);
      chk($sformatf("v%0d_req", v), {31'b0, ia.imem_req}, 32'h1);
      chk($sformatf("v%0d_addr", v), ia.imem_addr, vecs[v].exp_addr);
      sb_q.push_back('{pc: vecs[v].exp_addr, instr: vecs[v].exp_addr ^ K});
      ia.instr_ready = 1'b1;
      ack_pulse(vecs[v].exp_addr ^ K);
      drain($sformatf("v%0d_drain", v), 4);
    end

    // Reset pulsed mid-request, then a stray ACK while the request is low.
    do_reset(1'b0);
    cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'b0, ia.imem_req}, 32'h0);
    cycle();
    rst_n = 1'b1;
    ack_pulse(32'hDEAD_BEEF);
    chk("stray_valid", {31'b0, ia.instr_valid}, 32'h0);
    chk("stray_req", {31'b0, ia.imem_req}, 32'h1);
    chk("stray_addr", ia.imem_addr, 32'h0);
    cycle();
    chk("stray_valid2", {31'b0, ia.instr_valid}, 32'h0);
    sb_q.push_back('{pc: 32'h0, instr: K});
    ia.instr_ready = 1'b1;
    ack_pulse(K);
    drain("stray_drain", 4);

    // PC wrap on the second instance: memory acks every request immediately.
    begin
      logic [31:0] b_exp [3];
      int npop;
      b_exp[0] = 32'hFFFF_FFF8;
      b_exp[1] = 32'hFFFF_FFFC;
      b_exp[2] = 32'h0000_0000;
      npop = 0;
      ib.instr_ready = 1'b1;
      rst_nb = 1'b1;
      for (int i = 0; i < 30 && npop < 3; i++) begin
        if (ib.instr_valid) begin
          chk("wrap_pc", ib.instr_pc, b_exp[npop]);
          chk("wrap_instr", ib.instr, b_exp[npop] ^ K);
          npop++;
        end
        @(posedge clk);
        #1;
        ib.imem_ack = ib.imem_req;
        ib.imem_data = ib.imem_addr ^ K;
      end
      chk("wrap_count", 32'(npop), 32'd3);
      rst_nb = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RSTN  input  1  asynchronous, active-low reset.
REQ-004 REDIRECT  input  1  taken branch/jump; load TARGET as new PC.
REQ-005 TARGET  input  32  redirect address, driven by the next-PC mux output.
REQ-006 IMEM_REQ  output  1  fetch request to instruction memory, registered.
REQ-007 IMEM_ADDR  output  32  fetch address, registered.
REQ-008 IMEM_ACK  input  1  one-cycle pulse: IMEM_DATA valid, request complete.
REQ-009 IMEM_DATA  input  32  fetched instruction word.
REQ-010 INSTR  output  32  instruction at buffer head.
REQ-011 INSTR_PC  output  32  address of INSTR.
REQ-012 INSTR_VALID  output  1  buffer head valid.
REQ-013 INSTR_READY  input  1  decode accepts head.

Function
REQ-014 The block SHALL hold a 2-entry FIFO of {pc, instr}; INSTR/INSTR_PC SHALL show the head, INSTR_VALID = (occupancy > 0).
REQ-015 Pop SHALL occur on INSTR_VALID & INSTR_READY & !REDIRECT.
REQ-016 At most one request SHALL be outstanding; IMEM_REQ and IMEM_ADDR SHALL stay stable from assertion until the cycle IMEM_ACK is sampled high.
REQ-017 IMEM_ACK SHALL be ignored while IMEM_REQ is low.
REQ-018 On a non-discarded ACK the block SHALL push {IMEM_ADDR, IMEM_DATA} and set PC = IMEM_ADDR + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 IMEM_REQ SHALL be asserted at an edge only when occupancy after that edge's push/pop is at most 1; minimum ACK-to-next-REQ latency is one cycle.
REQ-020 Push and pop in the same cycle SHALL leave occupancy unchanged; a full buffer SHALL never be pushed.
REQ-021 FSM states: FETCH (request outstanding), HOLD (no request; buffer full), DROP (request outstanding whose data will be discarded).
REQ-022 FETCH -> HOLD on ACK when occupancy becomes 2; HOLD -> FETCH when occupancy drops below 2; FETCH -> FETCH on ACK with room.
REQ-023 REDIRECT SHALL flush the buffer (occupancy 0) and set PC = {TARGET[31:2], 2'b00} at the same edge; TARGET[1:0] ignored.
REQ-024 REDIRECT with request outstanding and no ACK that cycle SHALL enter DROP; IMEM_ADDR held until ACK, that data discarded, then FETCH at new PC next cycle.
REQ-025 REDIRECT coincident with ACK SHALL discard the ACK data; next cycle IMEM_REQ=1, IMEM_ADDR=new PC.
REQ-026 REDIRECT in DROP SHALL update PC to the latest TARGET and remain in DROP.
REQ-027 REDIRECT in HOLD or with IMEM_REQ low SHALL go to FETCH with IMEM_ADDR=new PC next cycle.
REQ-028 REDIRECT has priority over a simultaneous pop; INSTR_VALID SHALL be 0 in the cycle after any REDIRECT.

Reset
REQ-029 While RSTN=0: IMEM_REQ=0, IMEM_ADDR=RESET_PC, PC=RESET_PC, occupancy 0, INSTR_VALID=0, INSTR=0, INSTR_PC=0, state FETCH-idle.
REQ-030 First edge with RSTN=1 SHALL assert IMEM_REQ with IMEM_ADDR=RESET_PC.
REQ-031 Reset asserted mid-request SHALL abandon it; a later ACK with IMEM_REQ low SHALL be ignored.

Verification
REQ-032 Reset release, INSTR_READY=1, ACK 2 cycles after each REQ with DATA=addr^32'hA5A5A5A5 -> INSTR_PC sequence 0,4,8,... with matching INSTR, no gaps/duplicates.
REQ-033 INSTR_READY=0, ACK every request -> exactly 2 entries (PC 0,4) buffered, IMEM_REQ low in HOLD; READY=1 one cycle -> PC 0 popped, request for 8 issued next cycle.
REQ-034 REDIRECT TARGET=32'h0000_0100 while request for 8 outstanding, ACK 3 cycles later -> ACK data dropped, INSTR_VALID=0, next request addr 0x100, first INSTR_PC=0x100.
REQ-035 REDIRECT TARGET=32'h0000_0203 coincident with ACK -> data discarded, next IMEM_ADDR=0x200.
REQ-036 RESET_PC=32'hFFFF_FFF8, READY=1 -> INSTR_PC FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 RSTN pulsed low during outstanding request, stray ACK after -> no push, restart at RESET_PC.
